// File: rtl/operand_loader.sv
// operand_loader: debounced single-button entry of two 4-bit operands (and an
// optional carry-in) for a 4-bit adder, with synchronous clear and LED state.
// Optional feature: define OPERAND_LOADER_CIN_EN to add the WAIT_C step that
// captures cin from sw[0]; undefined, cin is constant 0 and WAIT_C is unused.
module operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic       clr,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       cin,
  output logic       valid,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    WAIT_C = 2'd2,
    READY  = 2'd3
  } state_t;

  logic             btn_s1, btn_s2;
  logic             clr_s1, clr_s2;
  logic             level, level_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             press;

  state_t           state_q, state_d;
  logic [3:0]       op_a_q, op_a_d;
  logic [3:0]       op_b_q, op_b_d;
  logic             valid_q, valid_d;

  // Two-flop synchronizers for the asynchronous button and clear inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      clr_s1 <= clr;
      clr_s2 <= clr_s1;
    end
  end

  assign cnt_inc = cnt + CNT_W'(1);

  // Debouncer: level follows the synchronized button only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; keeps running during clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      level_prev <= level;
      if (btn_s2 == level) begin
        cnt <= '0;
      end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= btn_s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

  // One-cycle press pulse in the cycle after the debounced level rises
  assign press = level & ~level_prev;

`ifdef OPERAND_LOADER_CIN_EN
  logic cin_q, cin_d;
`endif

  // FSM state and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_A;
      op_a_q  <= '0;
      op_b_q  <= '0;
      valid_q <= 1'b0;
`ifdef OPERAND_LOADER_CIN_EN
      cin_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      valid_q <= valid_d;
`ifdef OPERAND_LOADER_CIN_EN
      cin_q   <= cin_d;
`endif
    end
  end

  // Next-state and next-operand logic; clear outranks a simultaneous press
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
`ifdef OPERAND_LOADER_CIN_EN
    cin_d   = cin_q;
`endif
    if (clr_s2) begin
      state_d = WAIT_A;
      op_a_d  = '0;
      op_b_d  = '0;
`ifdef OPERAND_LOADER_CIN_EN
      cin_d   = 1'b0;
`endif
    end else if (press) begin
      case (state_q)
        WAIT_A: begin
          op_a_d  = sw;
          state_d = WAIT_B;
        end
        WAIT_B: begin
          op_b_d  = sw;
`ifdef OPERAND_LOADER_CIN_EN
          state_d = WAIT_C;
`else
          state_d = READY;
`endif
        end
        WAIT_C: begin
`ifdef OPERAND_LOADER_CIN_EN
          cin_d   = sw[0];
          state_d = READY;
`else
          state_d = WAIT_A;
`endif
        end
        READY: begin
          op_a_d  = sw;
          state_d = WAIT_B;
        end
        default: state_d = WAIT_A;
      endcase
    end
    valid_d = (state_d == READY);
  end

  assign op_a  = op_a_q;
  assign op_b  = op_b_q;
  assign valid = valid_q;
  assign state = state_q;
`ifdef OPERAND_LOADER_CIN_EN
  assign cin   = cin_q;
`else
  assign cin   = 1'b0;
`endif

endmodule
